alu_seq_acc: RTL and testbench

//  Parametrised, registered successor to the 4-bit combinational board ALU. Adds a result/accumulator

---
 rtl/alu_seq_acc_pkg.sv | 28 ++
 rtl/alu_seq_acc_mult.sv | 86 ++++++++
 rtl/alu_seq_acc.sv | 135 +++++++++++++
 tb/tb_alu_seq_acc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_acc_pkg.sv
// Shared definitions for the registered sequential ALU.
// Holds the operation codes, the control FSM state encoding and a small
// decode helper. There are no ports; alu_seq_acc and alu_seq_acc_mult import it.
package alu_seq_acc_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD  = 3'd0,
    FUNC_SUB  = 3'd1,
    FUNC_LOG  = 3'd2,
    FUNC_ROR  = 3'd3,
    FUNC_RAND = 3'd4,
    FUNC_CAT  = 3'd5,
    FUNC_SHL  = 3'd6,
    FUNC_MUL  = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply is the only operation that leaves IDLE.
  function automatic logic is_multi_cycle(input logic [2:0] func);
    return (func == FUNC_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_acc_mult.sv
// Shift-add unsigned multiplier. It adds one partial product per cycle, taking
// the multiplier LSB first, and finishes WIDTH cycles after start.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (aborts a multiply)
//   start       : load operands and begin (one-cycle pulse)
//   a, b        : multiplicand and multiplier, WIDTH bits
//   product     : 2*WIDTH-bit product, valid while done=1
//   done        : high on the cycle that performs the last step
module alu_seq_acc_mult
  import alu_seq_acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // Next-state logic for one shift-add step per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = {(2*WIDTH){1'b0}};
      cnt_d    = {CW{1'b0}};
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      // The final step's sum is handed out combinationally, so the caller can
      // capture it on the same edge that retires the last partial product.
      if (cnt_q == CW'(WIDTH - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  assign product = acc_d;

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_seq_acc.sv
// Registered sequential ALU with an accumulator and a valid/ready request port.
// Single-cycle operations complete one cycle after they are accepted. A multiply
// goes through MUL for WIDTH cycles and then DONE.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid / in_ready : request handshake; in_ready is high only in IDLE
//   func, a, b, use_acc : operation, operands and accumulator-feedback select
//   result              : 2*WIDTH-bit registered result/accumulator
//   out_valid           : one-cycle pulse when result is updated
//   busy                : high while the multiplier is stepping
module alu_seq_acc
  import alu_seq_acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               use_acc,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  output logic               busy
);

  localparam logic [WIDTH:0] SHL_LIMIT = (WIDTH + 1)'(2 * WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   b_eff_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [2*WIDTH-1:0] shl_s, alu_res_s, mul_product_s;
  logic               mul_start_s, mul_done_s;

  // Feedback reads the registered result, so a request accepted on an
  // out_valid cycle sees the previously completed value.
  assign b_eff_s = use_acc ? result_q[WIDTH-1:0] : b;

  // Single-cycle operation datapath.
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b_eff_s};
    diff_s    = {1'b0, a} - {1'b0, b_eff_s};
    shl_s     = {{WIDTH{1'b0}}, b_eff_s} << a;
    alu_res_s = {(2*WIDTH){1'b0}};
    case (func_e'(func))
      FUNC_ADD:  alu_res_s = {{(WIDTH-1){1'b0}}, sum_s};
      FUNC_SUB:  alu_res_s = {{(WIDTH-1){diff_s[WIDTH]}}, diff_s};
      FUNC_LOG:  alu_res_s = {a | b_eff_s, a ^ b_eff_s};
      FUNC_ROR:  alu_res_s = {{(2*WIDTH-1){1'b0}}, |{a, b_eff_s}};
      FUNC_RAND: alu_res_s = {{(2*WIDTH-1){1'b0}}, &{a, b_eff_s}};
      FUNC_CAT:  alu_res_s = {a, b_eff_s};
      FUNC_SHL: begin
        if ({1'b0, a} >= SHL_LIMIT) begin
          alu_res_s = {(2*WIDTH){1'b0}};
        end else begin
          alu_res_s = shl_s;
        end
      end
      FUNC_MUL:  alu_res_s = {(2*WIDTH){1'b0}};
      default:   alu_res_s = {(2*WIDTH){1'b0}};
    endcase
  end

  alu_seq_acc_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_s),
    .a       (a),
    .b       (b_eff_s),
    .product (mul_product_s),
    .done    (mul_done_s)
  );

  // Control FSM: next state, result update and completion pulse.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_multi_cycle(func)) begin
            mul_start_s = 1'b1;
            state_d     = ST_MUL;
          end else begin
            result_d    = alu_res_s;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        // Load on the last step so out_valid is seen in DONE.
        if (mul_done_s) begin
          result_d    = mul_product_s;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= {(2*WIDTH){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_acc.sv
module tb_alu_seq_acc;

  typedef struct {
    logic [7:0] res;
    int         due;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, use_acc, out_valid, busy;
  logic [2:0]  func;
  logic [3:0]  a, b;
  logic [7:0]  result;

  logic        in_valid8, in_ready8, use_acc8, out_valid8, busy8;
  logic [2:0]  func8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [7:0] model_res = 8'h00;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_acc #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .a(a), .b(b), .use_acc(use_acc),
    .result(result), .out_valid(out_valid), .busy(busy)
  );

  alu_seq_acc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .func(func8), .a(a8), .b(b8), .use_acc(use_acc8),
    .result(result8), .out_valid(out_valid8), .busy(busy8)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour for WIDTH=4, written from the operation definitions.
  function automatic logic [7:0] model(input int f, input int av, input int bv);
    int r;
    case (f)
      0: r = av + bv;
      1: r = av - bv;
      2: r = ((av | bv) << 4) | (av ^ bv);
      3: r = ((av | bv) != 0) ? 1 : 0;
      4: r = ((av & bv) == 15) ? 1 : 0;
      5: r = (av << 4) | bv;
      6: r = (av >= 8) ? 0 : (bv << av);
      7: r = av * bv;
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  task automatic issue(input logic [2:0] f, input logic [3:0] av, input logic [3:0] bv,
                       input logic ua, input bit push, input string tag);
    exp_t e;
    logic [3:0] be;
    @(negedge clk);
    func = f; a = av; b = bv; use_acc = ua; in_valid = 1'b1;
    check_eq({tag, "_ready"}, 16'(in_ready), 16'd1);
    be = ua ? model_res[3:0] : bv;
    e.res = model(int'(f), int'(av), int'(be));
    e.due = cyc + ((f == 3'd7) ? 5 : 1);
    e.tag = tag;
    @(posedge clk);
    if (push) begin
      sb.push_back(e);
      model_res = e.res;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain_empty", 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  // Scoreboard: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      check_eq("out_valid_expected", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq(e.tag, 16'(result), 16'(e.res));
        check_eq({e.tag, "_lat"}, 16'(cyc), 16'(e.due));
      end
    end
  end

  int tf[10] = '{1, 2, 5, 6, 6, 3, 3, 4, 4, 0};
  int ta[10] = '{3, 10, 3, 3, 9, 0, 0, 15, 15, 7};
  int tb[10] = '{5, 6, 12, 15, 15, 0, 1, 15, 14, 9};

  initial begin
    int t0, lat8;
    logic [15:0] res8;
    logic [2:0] rf;
    reset = 1'b1; in_valid = 1'b0; func = 3'd0; a = 4'd0; b = 4'd0; use_acc = 1'b0;
    in_valid8 = 1'b0; func8 = 3'd0; a8 = 8'd0; b8 = 8'd0; use_acc8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_result", 16'(result), 16'h00);
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_ready", 16'(in_ready), 16'd1);

    issue(3'd0, 4'd9, 4'd8, 1'b0, 1'b1, "add_9_8");
    idle();
    drain();

    // Back-to-back single-cycle table.
    for (int i = 0; i < 10; i++) issue(3'(tf[i]), 4'(ta[i]), 4'(tb[i]), 1'b0, 1'b1, $sformatf("tbl%0d", i));
    idle();
    drain();

    // Multiply with a request pulsed while busy.
    issue(3'd7, 4'hF, 4'hF, 1'b0, 1'b1, "mul_ff");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        func = 3'd0; a = 4'd1; b = 4'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check_eq("mul_busy", 16'(busy), 16'd1);
      check_eq("mul_not_ready", 16'(in_ready), 16'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_busy", 16'(busy), 16'd0);
    check_eq("done_not_ready", 16'(in_ready), 16'd0);
    drain();
    check_eq("mul_hold", 16'(result), 16'hE1);

    // Accumulator chain.
    issue(3'd0, 4'd1, 4'd1, 1'b0, 1'b1, "chain1");
    issue(3'd0, 4'd1, 4'hF, 1'b1, 1'b1, "chain2");
    issue(3'd0, 4'd1, 4'hF, 1'b1, 1'b1, "chain3");
    idle();
    drain();
    check_eq("chain_final", 16'(result), 16'h04);

    // Reset held two cycles in the middle of a multiply.
    issue(3'd7, 4'hF, 4'hF, 1'b0, 1'b0, "mul_rst");
    idle();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_res = 8'h00;
    repeat (8) @(negedge clk);
    check_eq("abort_result", 16'(result), 16'h00);
    check_eq("abort_ready", 16'(in_ready), 16'd1);
    check_eq("abort_busy", 16'(busy), 16'd0);

    // Random operations, including feedback and multiplies.
    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom_range(0, 7));
      issue(rf, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d_f%0d", i, rf));
      if (rf == 3'd7) begin
        idle();
        drain();
      end
    end
    idle();
    drain();

    // Eight-bit multiply.
    @(negedge clk);
    func8 = 3'd7; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    check_eq("w8_ready", 16'(in_ready8), 16'd1);
    t0 = cyc;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat8 = -1;
    res8 = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      if (lat8 < 0 && out_valid8) begin
        lat8 = cyc - t0;
        res8 = result8;
      end
      @(negedge clk);
    end
    check_eq("w8_mul_lat", 16'(lat8), 16'd9);
    check_eq("w8_mul_res", res8, 16'hFE01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
